// File: rtl/vsm_program_counter_if.sv
// Sequencer-facing bundle for the VSM program counter: control requests in, PC and stack status out.
// The sequencer holds the master modport and the counter holds the slave modport.
interface vsm_program_counter_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             EnableCount;
    logic             Load;
    logic             Call;
    logic             Ret;
    logic [WIDTH-1:0] Target;
    logic [WIDTH-1:0] PC;
    logic [DW-1:0]    StackDepth;
    logic             StackFull;
    logic             StackEmpty;
    logic             Wrap;
    logic             StackErr;

    modport master (
        output EnableCount, Load, Call, Ret, Target,
        input  PC, StackDepth, StackFull, StackEmpty, Wrap, StackErr
    );

    modport slave (
        input  EnableCount, Load, Call, Ret, Target,
        output PC, StackDepth, StackFull, StackEmpty, Wrap, StackErr
    );
endinterface

// File: rtl/vsm_program_counter.sv
// Parametrised VSM program counter with jump, bounded call/return stack, wrap pulse and sticky stack error.
// Request priority when enabled: Ret, then Call, then Load, then plain increment.
module vsm_program_counter #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input logic                   MainClock,
    input logic                   ClearCounter,
    vsm_program_counter_if.slave  bus
);
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** DW;

    typedef logic [WIDTH-1:0] addr_t;

    addr_t          pcReg;
    logic [DW-1:0]  depthReg;
    logic           wrapReg;
    logic           errReg;
    addr_t          stackMem [SLOTS];
    addr_t          pcPlusOne;
    logic           isFull;
    logic           isEmpty;

    // The stack is sized to the full range of the depth register so it can be indexed without truncation.
    assign pcPlusOne = pcReg + WIDTH'(1);
    assign isFull    = (depthReg == DW'(DEPTH));
    assign isEmpty   = (depthReg == '0);

    always_ff @(posedge MainClock) begin
        if (ClearCounter) begin
            pcReg    <= WIDTH'(RESET_PC);
            depthReg <= '0;
            wrapReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            wrapReg <= 1'b0;
            if (bus.EnableCount) begin
                if (bus.Ret) begin
                    if (!isEmpty) begin
                        pcReg    <= stackMem[depthReg - DW'(1)];
                        depthReg <= depthReg - DW'(1);
                    end else begin
                        errReg <= 1'b1;
                    end
                end else if (bus.Call) begin
                    // Return address is the instruction after the call; a full stack rejects the call outright.
                    if (!isFull) begin
                        stackMem[depthReg] <= pcPlusOne;
                        depthReg           <= depthReg + DW'(1);
                        pcReg              <= bus.Target;
                    end else begin
                        errReg <= 1'b1;
                    end
                end else if (bus.Load) begin
                    pcReg <= bus.Target;
                end else begin
                    pcReg   <= pcPlusOne;
                    wrapReg <= (pcReg == '1);
                end
            end
        end
    end

    assign bus.PC         = pcReg;
    assign bus.StackDepth = depthReg;
    assign bus.StackFull  = isFull;
    assign bus.StackEmpty = isEmpty;
    assign bus.Wrap       = wrapReg;
    assign bus.StackErr   = errReg;

endmodule

// File: tb/tb_vsm_program_counter.sv
// Self-checking bench for vsm_program_counter (WIDTH=4, DEPTH=4, RESET_PC=0).
// Expected snapshots from a reference model are queued per edge and popped once the DUT has updated.
module tb_vsm_program_counter;
    typedef struct packed {
        logic [3:0] pc;
        logic [2:0] depth;
        logic       full;
        logic       empty;
        logic       wrap;
        logic       err;
    } snap_t;

    logic MainClock = 1'b0;
    logic ClearCounter;

    vsm_program_counter_if #(.WIDTH(4), .DEPTH(4)) pcBus ();

    vsm_program_counter #(.WIDTH(4), .DEPTH(4), .RESET_PC(0)) dut (
        .MainClock    (MainClock),
        .ClearCounter (ClearCounter),
        .bus          (pcBus.slave)
    );

    always #5 MainClock = ~MainClock;

    int compared   = 0;
    int mismatched = 0;
    snap_t sb[$];
    snap_t expSnap;
    snap_t obsSnap;

    logic [3:0] mPc;
    int         mDepth;
    logic [3:0] mStack [4];
    logic       mWrap;
    logic       mErr;

    // Applies one cycle of stimulus, advances the reference model and queues what the DUT should show.
    task automatic drive(input logic clr, input logic en, input logic ld, input logic cl,
                         input logic rt, input logic [3:0] tgt);
        ClearCounter      = clr;
        pcBus.EnableCount = en;
        pcBus.Load        = ld;
        pcBus.Call        = cl;
        pcBus.Ret         = rt;
        pcBus.Target      = tgt;
        mWrap = 1'b0;
        if (clr) begin
            mPc = 4'd0; mDepth = 0; mErr = 1'b0;
        end else if (en) begin
            if (rt) begin
                if (mDepth > 0) begin mDepth--; mPc = mStack[mDepth]; end
                else mErr = 1'b1;
            end else if (cl) begin
                if (mDepth < 4) begin mStack[mDepth] = 4'((int'(mPc) + 1) % 16); mDepth++; mPc = tgt; end
                else mErr = 1'b1;
            end else if (ld) begin
                mPc = tgt;
            end else begin
                mWrap = (mPc == 4'd15);
                mPc = 4'((int'(mPc) + 1) % 16);
            end
        end
        sb.push_back('{pc: mPc, depth: 3'(mDepth), full: (mDepth == 4), empty: (mDepth == 0),
                       wrap: mWrap, err: mErr});
        @(posedge MainClock);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 4'd0);
        if (sb.size() == 0) begin mismatched++; $display("[TB] FAIL reset.queue got empty want 1 entry"); end
        else begin
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap) begin
                mismatched++;
                $display("[TB] FAIL reset.snap got %h want %h", obsSnap, expSnap);
            end
        end
        compared++;
        if (pcBus.PC !== 4'd0 || pcBus.StackEmpty !== 1'b1 || pcBus.StackErr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset.const got pc=%0d empty=%b err=%b want pc=0 empty=1 err=0",
                     pcBus.PC, pcBus.StackEmpty, pcBus.StackErr);
        end
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 17; i++) begin
            drive(0, 1, 0, 0, 0, 4'd0);
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap) begin
                mismatched++;
                $display("[TB] FAIL incr.snap[%0d] got %h want %h", i, obsSnap, expSnap);
            end
            compared++;
            if (pcBus.PC !== 4'(i % 16) || pcBus.Wrap !== (i == 16)) begin
                mismatched++;
                $display("[TB] FAIL incr.const[%0d] got pc=%0d wrap=%b want pc=%0d wrap=%b",
                         i, pcBus.PC, pcBus.Wrap, i % 16, (i == 16));
            end
        end
    endtask

    task automatic test_enable_gating();
        drive(0, 1, 1, 0, 0, 4'd6);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 4'd0);
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap || pcBus.PC !== 4'd6 || pcBus.Wrap !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL hold[%0d] got %h want %h (pc 6)", i, obsSnap, expSnap);
            end
        end
        drive(1, 1, 1, 0, 0, 4'd9);
        expSnap = sb.pop_front();
        compared++;
        if (pcBus.PC !== 4'd0 || pcBus.PC !== expSnap.pc) begin
            mismatched++;
            $display("[TB] FAIL resetPrio.pc got %0d want 0", pcBus.PC);
        end
    endtask

    task automatic test_jump();
        logic [3:0] want [8] = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, (i == 3), 0, 0, 4'd12);
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap || pcBus.PC !== want[i] || pcBus.Wrap !== (i == 7)
                || pcBus.StackDepth !== 3'd0) begin
                mismatched++;
                $display("[TB] FAIL jump[%0d] got %h pc=%0d want %h pc=%0d", i, obsSnap, pcBus.PC, expSnap, want[i]);
            end
        end
    endtask

    task automatic test_nested_call();
        // Stimulus rows: {ld, call, ret, target, wantPc, wantDepth}
        int rows [8][6] = '{'{0,0,0,0,1,0}, '{0,0,0,0,2,0}, '{0,1,0,8,8,1}, '{0,0,0,0,9,1},
                            '{0,1,0,12,12,2}, '{0,0,1,0,10,1}, '{0,0,1,0,3,0}, '{0,0,0,0,4,0}};
        drive(1, 0, 0, 0, 0, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, rows[i][0][0], rows[i][1][0], rows[i][2][0], 4'(rows[i][3]));
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap || pcBus.PC !== 4'(rows[i][4]) || pcBus.StackDepth !== 3'(rows[i][5])) begin
                mismatched++;
                $display("[TB] FAIL nested[%0d] got pc=%0d depth=%0d want pc=%0d depth=%0d",
                         i, pcBus.PC, pcBus.StackDepth, rows[i][4], rows[i][5]);
            end
        end
    endtask

    task automatic test_stack_bounds();
        // Rows: {call, ret, target, wantPc, wantDepth, wantErr}
        int rows [13][6] = '{'{1,0,5,5,1,0}, '{1,0,9,9,2,0}, '{1,0,13,13,3,0}, '{1,0,2,2,4,0},
                             '{1,0,7,2,4,1}, '{0,1,0,14,3,1}, '{0,1,0,10,2,1}, '{0,1,0,6,1,1},
                             '{0,1,0,1,0,1}, '{0,1,0,1,0,1}, '{0,0,0,2,0,1}, '{0,0,0,3,0,1},
                             '{1,0,15,15,1,1}};
        drive(1, 0, 0, 0, 0, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 0, rows[i][0][0], rows[i][1][0], 4'(rows[i][2]));
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap || pcBus.PC !== 4'(rows[i][3]) || pcBus.StackDepth !== 3'(rows[i][4])
                || pcBus.StackErr !== rows[i][5][0] || pcBus.StackFull !== (rows[i][4] == 4)) begin
                mismatched++;
                $display("[TB] FAIL bounds[%0d] got pc=%0d depth=%0d err=%b want pc=%0d depth=%0d err=%0d",
                         i, pcBus.PC, pcBus.StackDepth, pcBus.StackErr, rows[i][3], rows[i][4], rows[i][5]);
            end
        end
        drive(1, 0, 0, 0, 0, 4'd0);
        expSnap = sb.pop_front();
        compared++;
        if (pcBus.StackErr !== 1'b0 || pcBus.StackErr !== expSnap.err) begin
            mismatched++;
            $display("[TB] FAIL errClear got %b want 0", pcBus.StackErr);
        end
    endtask

    task automatic test_simultaneous();
        // Rows: {ld, call, ret, target, wantPc, wantDepth}
        int rows [11][6] = '{'{1,0,0,4,4,0}, '{0,1,0,0,0,1}, '{1,1,1,9,5,0}, '{1,0,0,1,1,0},
                             '{1,1,0,7,7,1}, '{0,0,1,0,2,0}, '{1,0,0,15,15,0}, '{0,1,0,0,0,1},
                             '{0,0,1,0,0,0}, '{1,0,0,0,0,0}, '{0,0,0,0,1,0}};
        for (int i = 0; i < 11; i++) begin
            drive(0, 1, rows[i][0][0], rows[i][1][0], rows[i][2][0], 4'(rows[i][3]));
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap || pcBus.PC !== 4'(rows[i][4]) || pcBus.StackDepth !== 3'(rows[i][5])
                || pcBus.Wrap !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL simul[%0d] got pc=%0d depth=%0d wrap=%b want pc=%0d depth=%0d wrap=0",
                         i, pcBus.PC, pcBus.StackDepth, pcBus.Wrap, rows[i][4], rows[i][5]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] r;
        for (int i = 0; i < 300; i++) begin
            r = 5'($urandom);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0), r[0] & r[1], r[2] & r[3],
                  r[4] & r[0], 4'($urandom));
            expSnap = sb.pop_front();
            obsSnap = {pcBus.PC, pcBus.StackDepth, pcBus.StackFull, pcBus.StackEmpty, pcBus.Wrap, pcBus.StackErr};
            compared++;
            if (obsSnap !== expSnap) begin
                mismatched++;
                $display("[TB] FAIL random[%0d] got %h want %h", i, obsSnap, expSnap);
            end
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue.drain got %0d want 0", sb.size());
        end
    endtask

    initial begin
        ClearCounter      = 1'b1;
        pcBus.EnableCount = 1'b0;
        pcBus.Load        = 1'b0;
        pcBus.Call        = 1'b0;
        pcBus.Ret         = 1'b0;
        pcBus.Target      = 4'd0;
        mPc = 4'd0; mDepth = 0; mWrap = 1'b0; mErr = 1'b0;
        for (int i = 0; i < 4; i++) mStack[i] = 4'd0;
        test_reset();
        test_increment();
        test_enable_gating();
        test_jump();
        test_nested_call();
        test_stack_bounds();
        test_simultaneous();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
